// File: rtl/mul_sched_pkg.sv
// Shared types and sizing for the two-lane multiplier share scheduler.
package mul_sched_pkg;

    localparam int unsigned DATA_W             = 32;
    localparam int unsigned RD_W               = 5;
    localparam int unsigned LANE_W             = 1;
    localparam int unsigned TIMEOUT_CYCLES_DEF = 40;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_e;

    typedef logic [LANE_W-1:0] lane_t;

    typedef struct packed {
        logic [DATA_W-1:0] op_a;
        logic [DATA_W-1:0] op_b;
        logic [RD_W-1:0]   rd;
    } mul_cmd_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-requester round-robin arbiter; the pointer moves past the winner on an accepted grant.
module rr_arbiter2
    import mul_sched_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic [1:0] req,
    input  logic       accept,
    output logic [1:0] gnt_c,
    output lane_t      winner_c
);

    lane_t ptr_q;

    always_comb begin
        winner_c = lane_t'(0);
        gnt_c    = 2'b00;
        if (req[0] && req[1]) begin
            winner_c = ptr_q;
        end else if (req[1]) begin
            winner_c = lane_t'(1);
        end
        if (|req) begin
            gnt_c[winner_c] = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ptr_q <= lane_t'(0);
        end else if (accept && |req) begin
            ptr_q <= ~winner_c;
        end
    end

endmodule

// File: rtl/mul_share_scheduler.sv
// Shares one multiplier between two request lanes: one owned operation at a time,
// round-robin grant, timeout abort, flush/drop handling and a one-entry rd scoreboard.
module mul_share_scheduler
    import mul_sched_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              req0_valid_i,
    output logic              req0_ready_o,
    input  logic [DATA_W-1:0] req0_op_a_i,
    input  logic [DATA_W-1:0] req0_op_b_i,
    input  logic [RD_W-1:0]   req0_rd_idx_i,
    input  logic              req1_valid_i,
    output logic              req1_ready_o,
    input  logic [DATA_W-1:0] req1_op_a_i,
    input  logic [DATA_W-1:0] req1_op_b_i,
    input  logic [RD_W-1:0]   req1_rd_idx_i,
    output logic              resp0_valid_o,
    input  logic              resp0_ready_i,
    output logic              resp1_valid_o,
    input  logic              resp1_ready_i,
    output logic [DATA_W-1:0] resp_result_o,
    output logic [RD_W-1:0]   resp_rd_idx_o,
    input  logic              flush_i,
    output logic              mul_start_o,
    output logic [DATA_W-1:0] mul_op_a_o,
    output logic [DATA_W-1:0] mul_op_b_o,
    output logic [RD_W-1:0]   mul_rd_idx_o,
    input  logic              mul_busy_i,
    input  logic              mul_valid_i,
    input  logic [DATA_W-1:0] mul_result_i,
    input  logic [RD_W-1:0]   mul_rd_idx_i,
    output logic              pending_o,
    output logic [RD_W-1:0]   pending_rd_o,
    output logic              err_timeout_o,
    output logic              err_rd_o
);

    localparam int unsigned TIMER_W = $clog2(TIMEOUT_CYCLES + 1);

    state_e            state_q, state_d;
    mul_cmd_t          cmd_q, cmd_d, cmd0_c, cmd1_c;
    lane_t             owner_q, owner_d, winner_c;
    logic [DATA_W-1:0] result_q, result_d;
    logic              drop_q, drop_d;
    logic [TIMER_W-1:0] timer_q, timer_d;
    logic              err_to_d, err_rd_d;
    logic              grant_ok_c, own_ready_c;
    logic [1:0]        req_c, gnt_c;

    assign req_c       = {req1_valid_i, req0_valid_i};
    assign cmd0_c      = {req0_op_a_i, req0_op_b_i, req0_rd_idx_i};
    assign cmd1_c      = {req1_op_a_i, req1_op_b_i, req1_rd_idx_i};
    assign grant_ok_c  = (state_q == ST_IDLE) && !mul_busy_i && !flush_i;
    assign own_ready_c = (owner_q == lane_t'(1)) ? resp1_ready_i : resp0_ready_i;

    rr_arbiter2 u_arb (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .req      (req_c),
        .accept   (grant_ok_c),
        .gnt_c    (gnt_c),
        .winner_c (winner_c)
    );

    assign req0_ready_o = grant_ok_c && gnt_c[0];
    assign req1_ready_o = grant_ok_c && gnt_c[1];

    assign mul_op_a_o    = cmd_q.op_a;
    assign mul_op_b_o    = cmd_q.op_b;
    assign mul_rd_idx_o  = cmd_q.rd;
    assign resp_result_o = result_q;
    assign resp_rd_idx_o = cmd_q.rd;

    // Next-state and next-register values; a dropped operation still waits out the multiplier.
    always_comb begin
        state_d  = state_q;
        cmd_d    = cmd_q;
        owner_d  = owner_q;
        result_d = result_q;
        drop_d   = drop_q;
        timer_d  = timer_q;
        err_to_d = 1'b0;
        err_rd_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (grant_ok_c && |req_c) begin
                    owner_d = winner_c;
                    cmd_d   = (winner_c == lane_t'(1)) ? cmd1_c : cmd0_c;
                    state_d = ST_START;
                end
            end
            ST_START: begin
                timer_d = '0;
                drop_d  = drop_q || flush_i;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                timer_d = timer_q + TIMER_W'(1);
                drop_d  = drop_q || flush_i;
                if (mul_valid_i) begin
                    result_d = mul_result_i;
                    err_rd_d = (mul_rd_idx_i != cmd_q.rd);
                    state_d  = drop_d ? ST_IDLE : ST_RESP;
                end else if (timer_q == TIMER_W'(TIMEOUT_CYCLES - 1)) begin
                    err_to_d = 1'b1;
                    state_d  = ST_IDLE;
                end
            end
            ST_RESP: begin
                if (flush_i || own_ready_c) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (state_d == ST_IDLE) begin
            drop_d = 1'b0;
        end
    end

    // State register plus outputs registered from next-state decode.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= ST_IDLE;
            cmd_q         <= '0;
            owner_q       <= lane_t'(0);
            result_q      <= '0;
            drop_q        <= 1'b0;
            timer_q       <= '0;
            mul_start_o   <= 1'b0;
            resp0_valid_o <= 1'b0;
            resp1_valid_o <= 1'b0;
            pending_o     <= 1'b0;
            pending_rd_o  <= '0;
            err_timeout_o <= 1'b0;
            err_rd_o      <= 1'b0;
        end else begin
            state_q       <= state_d;
            cmd_q         <= cmd_d;
            owner_q       <= owner_d;
            result_q      <= result_d;
            drop_q        <= drop_d;
            timer_q       <= timer_d;
            mul_start_o   <= (state_d == ST_START);
            resp0_valid_o <= (state_d == ST_RESP) && (owner_d == lane_t'(0));
            resp1_valid_o <= (state_d == ST_RESP) && (owner_d == lane_t'(1));
            pending_o     <= (state_d != ST_IDLE) && !drop_d;
            pending_rd_o  <= ((state_d != ST_IDLE) && !drop_d) ? cmd_d.rd : '0;
            err_timeout_o <= err_to_d;
            err_rd_o      <= err_rd_d;
        end
    end

endmodule
